chip8_alu_seq: RTL and testbench

- Owns the sixteen 8-bit general registers V0–VF.
- Sequences CHIP8 8XYN (register-register arithmetic/logic) instructions through the registered ALU stage directly downstream of it.
- Feeds the ALU Vx/Vy operands and N as the opcode, captures the ALU's 1-cycle-latency result, and writes back Vx, Vy (shifts only) and the VF flag in CHIP8-correct order.
- Other instruction types load registers through a simple external write port.

---
 rtl/chip8_alu_seq.sv | 155 +++++++++++++++
 tb/tb_chip8_alu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_seq.sv
// CHIP8 8XYN sequencer: owns V0-VF, drives a registered ALU stage and writes
// back Vy (shifts), Vx and VF in Y -> X -> F order so later writes win.
module chip8_alu_seq #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic [7:0]  alu_op1,
   output logic [7:0]  alu_op2,
   output logic [3:0]  alu_opcode,
   input  logic [7:0]  alu_out,
   input  logic        alu_carry,
   input  logic        alu_err,
   input  logic        ext_we,
   input  logic [3:0]  ext_addr,
   input  logic [7:0]  ext_wdata,
   input  logic [3:0]  dbg_addr,
   output logic [7:0]  dbg_data
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, CAPTURE, WB_Y, WB_X, WB_F
   } state_t;

   // ISSUE already covers one ALU cycle; WAIT supplies the remaining ones.
   localparam logic [7:0] WAIT_LAST = 8'(ALU_LAT > 1 ? ALU_LAT - 2 : 0);

   state_t      state, next_state;
   logic [7:0]  regs [16];
   logic [3:0]  x, y, n;
   logic [7:0]  res;
   logic        flag;
   logic [7:0]  wait_cnt;

   logic        accept, is_8xy, ext_ok, has_flag, is_shift;
   logic        wr_x, wr_y, wr_f;
   logic        retire, retire_err;
   logic [7:0]  op1_src, op2_src;

   assign accept   = (state == IDLE) && instr_valid;
   assign is_8xy   = (instr[15:12] == 4'h8);
   assign ext_ok   = ext_we && !busy;
   assign has_flag = (n == 4'h4) || (n == 4'h5) || (n == 4'h6) || (n == 4'h7) || (n == 4'hE);
   assign is_shift = (n == 4'h6) || (n == 4'hE);
   assign dbg_data = regs[dbg_addr];

   // An external write in the accepting cycle is forwarded into the operands.
   assign op1_src = (ext_ok && ext_addr == instr[11:8]) ? ext_wdata : regs[instr[11:8]];
   assign op2_src = (ext_ok && ext_addr == instr[7:4])  ? ext_wdata : regs[instr[7:4]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state is always updated with non-blocking assignments
         // so every flop samples pre-edge values regardless of block ordering.
         state <= next_state;
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves next_state
      // unassigned, which would infer a latch.
      next_state = state;
      case (state)
         IDLE:    if (instr_valid && is_8xy) next_state = ISSUE;
         ISSUE:   next_state = (ALU_LAT > 1) ? WAIT : CAPTURE;
         WAIT:    if (wait_cnt == WAIT_LAST) next_state = CAPTURE;
         CAPTURE: begin
            if (alu_err)       next_state = IDLE;
            else if (is_shift) next_state = WB_Y;
            else               next_state = WB_X;
         end
         WB_Y:    next_state = WB_X;
         WB_X:    next_state = has_flag ? WB_F : IDLE;
         WB_F:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      instr_ready = 1'b0;
      busy        = 1'b1;
      wr_y        = 1'b0;
      wr_x        = 1'b0;
      wr_f        = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
         end
         WB_Y:    wr_y = 1'b1;
         WB_X:    wr_x = 1'b1;
         WB_F:    wr_f = 1'b1;
         default: ;
      endcase
   end

   assign retire_err = (accept && !is_8xy) || (state == CAPTURE && alu_err);
   assign retire     = retire_err || (state == WB_X && !has_flag) || (state == WB_F);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x          <= '0;
         y          <= '0;
         n          <= '0;
         res        <= '0;
         flag       <= 1'b0;
         wait_cnt   <= '0;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_opcode <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= retire;
         err  <= retire_err;
         wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
         if (accept) begin
            x <= instr[11:8];
            y <= instr[7:4];
            n <= instr[3:0];
         end
         if (accept && is_8xy) begin
            alu_op1    <= op1_src;
            alu_op2    <= op2_src;
            alu_opcode <= instr[3:0];
         end
         if (state == CAPTURE) begin
            res  <= alu_out;
            flag <= alu_carry;
         end
      end
   end

   // NOTE: the register file is reset explicitly because V0-VF must read zero
   // after reset; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         if (ext_ok) regs[ext_addr] <= ext_wdata;
         if (wr_y)   regs[y]        <= res;
         if (wr_x)   regs[x]        <= res;
         if (wr_f)   regs[15]       <= {7'b0, flag};
      end
   end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Directed bench for chip8_alu_seq with a behavioural registered CHIP8 ALU
// attached to its operand outputs.
module tb_chip8_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic        done, err, busy;
   logic [7:0]  alu_op1, alu_op2;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_out;
   logic        alu_carry, alu_err;
   logic        ext_we = 1'b0;
   logic [3:0]  ext_addr = '0;
   logic [7:0]  ext_wdata = '0;
   logic [3:0]  dbg_addr = '0;
   logic [7:0]  dbg_data;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   chip8_alu_seq #(.ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .done(done), .err(err), .busy(busy),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_err(alu_err),
      .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Returns {err, carry, result} for CHIP8 8XYN semantics; shifts act on Vy.
   function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
      logic [8:0] s;
      case (op)
         4'h0: return {2'b00, b};
         4'h1: return {2'b00, a | b};
         4'h2: return {2'b00, a & b};
         4'h3: return {2'b00, a ^ b};
         4'h4: begin s = {1'b0, a} + {1'b0, b}; return {1'b0, s[8], s[7:0]}; end
         4'h5: return {1'b0, a >= b, a - b};
         4'h6: return {1'b0, b[0], b >> 1};
         4'h7: return {1'b0, b >= a, b - a};
         4'hE: return {1'b0, b[7], b << 1};
         default: return {1'b1, 1'b0, 8'h00};
      endcase
   endfunction

   always @(posedge clk) {alu_err, alu_carry, alu_out} <= alu_fn(alu_op1, alu_op2, alu_opcode);

   typedef struct packed {
      logic [15:0]       instr;
      logic [2:0][11:0]  loads;   // {addr, data}, applied [2] first
      logic [2:0][11:0]  checks;  // {addr, expected}
      logic [3:0]        lat;     // accept edge to done-visible edge
      logic              err;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic ext_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      ext_we = 1'b1; ext_addr = a; ext_wdata = d;
      @(negedge clk);
      ext_we = 1'b0;
   endtask

   task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
      dbg_addr = a;
      #1;
      d = dbg_data;
   endtask

   // Called just after the accept edge; lat = edges until done is seen (-1 if never).
   task automatic wait_done(output int lat, output logic e);
      int c = 0;
      lat = -1;
      e = 1'b0;
      while (c <= 20 && !done) begin
         @(posedge clk); #1;
         c++;
      end
      if (done) begin
         lat = c;
         e = err;
      end
   endtask

   task automatic issue(input logic [15:0] w);
      @(negedge clk);
      check($sformatf("ready before 0x%h", w), 16'(instr_ready), 16'h1);
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   initial begin : stim
      int lat, dones, first_c, second_c;
      logic e;
      logic [7:0] d;

      //                 instr     loads                         checks                      lat err
      vecs[0]  = '{16'h8124, {12'h1F0, 12'h220, 12'h220}, {12'h110, 12'hF01, 12'h220}, 4'd4, 1'b0};
      vecs[1]  = '{16'h8125, {12'h110, 12'h220, 12'h220}, {12'h1F0, 12'hF00, 12'h220}, 4'd4, 1'b0};
      vecs[2]  = '{16'h8125, {12'h130, 12'h220, 12'h220}, {12'h110, 12'hF01, 12'h220}, 4'd4, 1'b0};
      vecs[3]  = '{16'h8236, {12'h305, 12'h305, 12'h305}, {12'h202, 12'h302, 12'hF01}, 4'd5, 1'b0};
      vecs[4]  = '{16'h823E, {12'h381, 12'h381, 12'h381}, {12'h202, 12'h302, 12'hF01}, 4'd5, 1'b0};
      vecs[5]  = '{16'h8F14, {12'hFFF, 12'h101, 12'h101}, {12'hF01, 12'h101, 12'h101}, 4'd4, 1'b0};
      vecs[6]  = '{16'h8452, {12'h4AA, 12'h50F, 12'hF33}, {12'h40A, 12'h50F, 12'hF33}, 4'd3, 1'b0};
      vecs[7]  = '{16'h8451, {12'h4A0, 12'h50F, 12'hF33}, {12'h4AF, 12'h50F, 12'hF33}, 4'd3, 1'b0};
      vecs[8]  = '{16'h8453, {12'h4FF, 12'h50F, 12'hF33}, {12'h4F0, 12'h50F, 12'hF33}, 4'd3, 1'b0};
      vecs[9]  = '{16'h8450, {12'h412, 12'h534, 12'hF33}, {12'h434, 12'h534, 12'hF33}, 4'd3, 1'b0};
      vecs[10] = '{16'h8457, {12'h410, 12'h530, 12'hF00}, {12'h420, 12'h530, 12'hF01}, 4'd4, 1'b0};
      vecs[11] = '{16'h8457, {12'h430, 12'h510, 12'hF01}, {12'h4E0, 12'h510, 12'hF00}, 4'd4, 1'b0};
      vecs[12] = '{16'h8116, {12'h103, 12'h103, 12'hF00}, {12'h101, 12'hF01, 12'h101}, 4'd5, 1'b0};
      vecs[13] = '{16'h8128, {12'h111, 12'h222, 12'hF77}, {12'h111, 12'h222, 12'hF77}, 4'd2, 1'b1};
      vecs[14] = '{16'h6123, {12'h111, 12'h222, 12'hF77}, {12'h111, 12'h222, 12'hF77}, 4'd0, 1'b1};

      // Reset state, including dbg_data while reset is held.
      #2;
      for (int i = 0; i < 16; i++) begin
         read_reg(4'(i), d);
         check($sformatf("reset V%0h", i), 16'(d), 16'h00);
      end
      check("reset instr_ready", 16'(instr_ready), 16'h1);
      check("reset done", 16'(done), 16'h0);
      check("reset err", 16'(err), 16'h0);
      check("reset busy", 16'(busy), 16'h0);
      check("reset alu_op1", 16'(alu_op1), 16'h00);
      check("reset alu_op2", 16'(alu_op2), 16'h00);
      check("reset alu_opcode", 16'(alu_opcode), 16'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         for (int j = 2; j >= 0; j--) ext_write(vecs[i].loads[j][11:8], vecs[i].loads[j][7:0]);
         issue(vecs[i].instr);
         if (vecs[i].instr[15:12] == 4'h8)
            check($sformatf("v%0d busy", i), 16'(busy), 16'h1);
         wait_done(lat, e);
         check($sformatf("v%0d latency", i), 16'(lat), 16'(vecs[i].lat));
         check($sformatf("v%0d err", i), 16'(e), 16'(vecs[i].err));
         @(posedge clk); #1;
         check($sformatf("v%0d done pulse width", i), 16'(done), 16'h0);
         for (int j = 2; j >= 0; j--) begin
            read_reg(vecs[i].checks[j][11:8], d);
            check($sformatf("v%0d V%0h", i, vecs[i].checks[j][11:8]), 16'(d),
                  16'(vecs[i].checks[j][7:0]));
         end
      end

      // External write while busy is dropped.
      ext_write(4'h7, 8'h11);
      ext_write(4'h1, 8'h10);
      ext_write(4'h2, 8'h20);
      issue(16'h8124);
      @(negedge clk);
      ext_we = 1'b1; ext_addr = 4'h7; ext_wdata = 8'h55;
      @(negedge clk);
      ext_we = 1'b0;
      wait_done(lat, e);
      check("busy drop latency", 16'(lat), 16'd3);
      read_reg(4'h7, d);
      check("busy drop V7", 16'(d), 16'h11);
      read_reg(4'h1, d);
      check("busy drop V1", 16'(d), 16'h30);

      // External write coincident with acceptance is forwarded into the operands.
      ext_write(4'h1, 8'h01);
      ext_write(4'h2, 8'h01);
      @(negedge clk);
      ext_we = 1'b1; ext_addr = 4'h1; ext_wdata = 8'h40;
      instr = 16'h8124; instr_valid = 1'b1;
      @(posedge clk); #1;
      ext_we = 1'b0; instr_valid = 1'b0;
      check("fwd alu_op1", 16'(alu_op1), 16'h40);
      check("fwd alu_op2", 16'(alu_op2), 16'h01);
      wait_done(lat, e);
      read_reg(4'h1, d);
      check("fwd V1", 16'(d), 16'h41);
      read_reg(4'hF, d);
      check("fwd VF", 16'(d), 16'h00);

      // Back-to-back with instr_valid held through the first done cycle.
      ext_write(4'h1, 8'h01);
      ext_write(4'h2, 8'h01);
      @(negedge clk);
      instr = 16'h8124; instr_valid = 1'b1;
      @(posedge clk); #1;
      dones = 0; first_c = -1; second_c = -1;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         if (done) begin
            dones++;
            if (dones == 1) first_c = c; else second_c = c;
         end
         if (c == 4) check("b2b ready in done cycle", 16'(instr_ready), 16'h1);
         if (c == 5) instr_valid = 1'b0;
      end
      instr_valid = 1'b0;
      check("b2b done count", 16'(dones), 16'd2);
      check("b2b first done", 16'(first_c), 16'd4);
      check("b2b second done", 16'(second_c), 16'd9);
      read_reg(4'h1, d);
      check("b2b V1", 16'(d), 16'h03);

      // Reset asserted while in WB_X aborts the instruction.
      ext_write(4'h1, 8'h10);
      ext_write(4'h2, 8'h20);
      issue(16'h8124);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      read_reg(4'h1, d);
      check("abort V1", 16'(d), 16'h00);
      read_reg(4'h2, d);
      check("abort V2", 16'(d), 16'h00);
      read_reg(4'hF, d);
      check("abort VF", 16'(d), 16'h00);
      check("abort busy", 16'(busy), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("abort no done", 16'(dones), 16'd0);
      read_reg(4'h1, d);
      check("abort V1 after", 16'(d), 16'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, want summary");
      $fatal(1, "simulation time limit");
   end

endmodule
